// File: rtl/spike_event_fifo.sv
// Timestamps ON/OFF spike codes from the delta comparator and buffers them in a
// small first-word-fall-through FIFO with a valid/ready drain port.
module spike_event_fifo #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TS_WIDTH = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [1:0]          spike,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [TS_WIDTH:0]   out_data,
  output logic [4:0]          level,
  output logic                overflow
);

  localparam int unsigned W     = TS_WIDTH + 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [TS_WIDTH-1:0] ts;
  logic [W-1:0]        mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;

  logic                push_req;
  logic                push;
  logic                pop;
  logic [W-1:0]        event_word;
  logic [4:0]          level_next;
  logic [W-1:0]        head_next;

  assign push_req   = sample_valid & ((spike == 2'b01) | (spike == 2'b10));
  assign pop        = out_valid & out_ready;
  assign push       = push_req & ((level < 5'(DEPTH)) | pop);
  assign event_word = {spike == 2'b01, ts};

  // Next occupancy and next head word; the head is kept in its own register
  // so out_data comes straight from a flop.
  always_comb begin
    level_next = level;
    head_next  = out_data;
    if (push && !pop) begin
      level_next = level + 5'd1;
    end else if (pop && !push) begin
      level_next = level - 5'd1;
    end
    if (pop) begin
      if (level == 5'd1) begin
        head_next = event_word;
      end else begin
        head_next = mem[rd_ptr + PTR_W'(1)];
      end
    end else if ((level == 5'd0) && push) begin
      head_next = event_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts        <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (sample_valid) begin
        ts <= ts + TS_WIDTH'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_req && !push) begin
        overflow <= 1'b1;
      end
      level     <= level_next;
      out_valid <= (level_next != 5'd0);
      out_data  <= head_next;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= event_word;
    end
  end

endmodule

// File: tb/tb_spike_event_fifo.sv
// Scoreboard bench for spike_event_fifo: expected events are queued at stimulus
// time and a negedge monitor checks every word the DUT hands out.
module tb_spike_event_fifo;

  logic       clk;
  logic       reset;
  logic       sample_valid;
  logic [1:0] spike;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [4:0] level;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  spike_event_fifo #(.DEPTH(4), .TS_WIDTH(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .spike        (spike),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .level        (level),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted output word must match the oldest expected event.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got 0x%02h expected none", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          bad++;
          $display("FAIL event_word: got 0x%02h expected 0x%02h", out_data, e);
        end
      end
    end
  end

  task automatic step(input logic sv, input logic [1:0] sp);
    sample_valid = sv;
    spike        = sp;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    spike        = 2'b00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    spike        = 2'b00;
    out_ready    = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    do_reset();

    // 1: basic flow, one-cycle latency
    out_ready = 1'b1;
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h03);
    step(1'b1, 2'b00);
    chk("t1_idle_valid", out_valid, 0);
    step(1'b1, 2'b01);
    chk("t1_on_latency", out_valid, 1);
    step(1'b1, 2'b00);
    step(1'b1, 2'b10);
    chk("t1_off_latency", out_valid, 1);
    idle(3);
    chk("t1_level", level, 0);
    chk("t1_overflow", overflow, 0);
    chk("t1_drained", exp_q.size(), 0);

    // 2: fill, overflow on the fifth, then drain
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h80 | 8'(i));
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01);
    chk("t2_level_full", level, 4);
    chk("t2_overflow", overflow, 1);
    chk("t2_head", out_data, 8'h80);
    idle(2);
    chk("t2_head_hold", out_data, 8'h80);
    out_ready = 1'b1;
    idle(6);
    chk("t2_level_empty", level, 0);
    chk("t2_overflow_sticky", overflow, 1);
    chk("t2_drained", exp_q.size(), 0);

    // 3: push while full with simultaneous pop
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h80 | 8'(i));
    exp_q.push_back(8'h04);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01);
    out_ready = 1'b1;
    step(1'b1, 2'b10);
    out_ready = 1'b0;
    chk("t3_level", level, 4);
    chk("t3_overflow", overflow, 0);
    out_ready = 1'b1;
    idle(6);
    chk("t3_drained", exp_q.size(), 0);

    // 4: timestamp wrap after 128 samples
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h80);
    for (int i = 0; i < 130; i++) step(1'b1, (i == 0 || i == 128) ? 2'b01 : 2'b00);
    idle(2);
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_level", level, 0);

    // 5: illegal code advances ts, invalid sample does not
    do_reset();
    out_ready = 1'b1;
    step(1'b1, 2'b11);
    step(1'b0, 2'b01);
    chk("t5_level", level, 0);
    chk("t5_valid", out_valid, 0);
    exp_q.push_back(8'h81);
    step(1'b1, 2'b01);
    idle(2);
    chk("t5_drained", exp_q.size(), 0);

    // 6: asynchronous reset mid-cycle with level 3 and overflow set
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h80 | 8'(i));
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("t6_level_pre", level, 3);
    chk("t6_overflow_pre", overflow, 1);
    #3;
    reset = 1'b1;
    #2;
    chk("t6_level_async", level, 0);
    chk("t6_valid_async", out_valid, 0);
    chk("t6_overflow_async", overflow, 0);
    exp_q.delete();
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    exp_q.push_back(8'h80);
    step(1'b1, 2'b01);
    idle(2);
    chk("t6_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_event_fifo.md
Name: spike_event_fifo

Overview:
- Downstream stage of the delta comparator. Consumes its per-sample 2-bit spike code.
- Drops non-events. Tags each ON/OFF event with a sample-count timestamp.
- Buffers tagged events in a small first-word-fall-through FIFO.
- Presents events on a valid/ready output toward the serializer/IO stage, so spikes produced faster than the IO drains them are not lost until the buffer is full.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- TS_WIDTH, 7, timestamp counter width in bits; event word width is TS_WIDTH+1.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- sample_valid  input  1  high for one cycle per new input sample; spike is valid in that cycle.
- spike  input  2  comparator code: 00 none, 01 ON (rising), 10 OFF (falling), 11 illegal.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_valid  output  1  FIFO non-empty; out_data holds the oldest event.
- out_data  output  TS_WIDTH+1  [TS_WIDTH] polarity (1=ON, 0=OFF), [TS_WIDTH-1:0] timestamp.
- level  output  5  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when an event is dropped.

Behaviour:
- Reset is asynchronous and active-high, and may assert at any time, including mid-stream. It forces:
  - ts=0, level=0, out_valid=0, out_data=0, overflow=0, read/write pointers=0.
  - Buffered events are discarded.
- Timestamp counter ts (TS_WIDTH bits):
  - Increments by 1 on every cycle with sample_valid=1, regardless of spike value.
  - Wraps from 2^TS_WIDTH-1 to 0; no wrap marker is emitted.
  - An event captured in a cycle carries ts as it was before that cycle's increment. The first sample after reset is therefore stamped 0.
- Event detect:
  - push_req = sample_valid & (spike==01 | spike==10).
  - spike 00 and 11 never push. 11 is silently ignored, and ts still increments.
- Pop: pop = out_valid & out_ready.
- Push acceptance:
  - A push is accepted if level<DEPTH, or if level==DEPTH and pop is true in the same cycle.
  - At full with no pop, the event is dropped, overflow<=1, and FIFO contents are unchanged.
- Simultaneous push and pop:
  - Both happen and level is unchanged.
  - At level==0, a push with no pop is possible; a pop is not, since out_valid=0.
- Latency:
  - An event pushed in cycle N gives out_valid=1 in cycle N+1 when the FIFO was empty.
  - Otherwise it becomes head after all older entries pop.
- Output hold:
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_data value when out_valid=0 is don't-care; the bench must not check it.
- Pointers and level:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - level is computed from push/pop, not from pointer difference, so the full/empty ambiguity is resolved.
- overflow clears only on reset.
- No combinational path from spike/sample_valid to out_valid/out_data, so out_valid is registered. out_ready may combinationally affect nothing except internal pop.

Test Plan:
1. Reset, then sample_valid every cycle with spike sequence 00,01,00,10, out_ready=1 → two events out: {1, ts=1} then {0, ts=3}, each appearing one cycle after its input; level returns to 0; overflow=0.
2. out_ready=0, push 5 ON events on consecutive samples (DEPTH=4) → level=4, the 5th is dropped, overflow=1. Raise out_ready → timestamps 0,1,2,3 drain in order; overflow stays 1.
3. FIFO full, out_ready=1 and a push in the same cycle → the push is accepted, level stays 4, overflow stays 0, and the new event appears 4th in output order.
4. Drive 130 samples with spike 01 only on samples 0 and 128, TS_WIDTH=7 → event timestamps 0 and 0 (wrap), both ON.
5. spike=11 with sample_valid=1, and spike=01 with sample_valid=0 → no pushes, level stays 0; ts advances only for the first.
6. Assert reset asynchronously mid-cycle with level=3 and overflow=1 → level, out_valid and overflow go to 0 immediately without a clock edge; the next sample is stamped ts=0.
